reg_bus_sequencer: RTL

//  Sequences register-to-register transfers over the shared register bus, generating the
//  per-register drive (h) and capture (c) strobes. Accepts one command at a time via

---
 rtl/reg_bus_sequencer_pkg.sv | 33 +++
 rtl/reg_bus_sequencer_if.sv | 39 +++
 rtl/reg_bus_sequencer_idx_onehot_dec.sv | 26 ++
 rtl/reg_bus_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_pkg
// Description : Shared definitions for the register-bus sequencer: command
//               opcodes, FSM state encoding and the reserved TMP register index.
// Ports       : none (package)
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bus_pkg;

    typedef enum logic [1:0] {
        OP_MOVE = 2'b00,
        OP_SWAP = 2'b01,
        OP_LOAD = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // The highest-numbered bus register is reserved as the SWAP scratch.
    function automatic int tmp_idx(input int nreg);
        return nreg - 1;
    endfunction

endpackage : reg_bus_pkg
`default_nettype wire

// File: rtl/reg_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_sequencer_if
// Description : Command handshake and bus-strobe bundle between the command
//               source / bus datapath (master) and the sequencer (slave).
// Signals     : cmd_valid, cmd_op[1:0], cmd_src, cmd_dst  - command (to seq)
//               cmd_ready                                   - accept (from seq)
//               h[NREG], c[NREG], ext_drv                   - bus strobes
//               busy, done, err                             - status
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bus_sequencer_if #(
    parameter int NREG = 4,
    parameter int IDXW = 2
);
    logic            cmd_valid;
    logic [1:0]      cmd_op;
    logic [IDXW-1:0] cmd_src;
    logic [IDXW-1:0] cmd_dst;
    logic            cmd_ready;
    logic [NREG-1:0] h;
    logic [NREG-1:0] c;
    logic            ext_drv;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst,
        input  cmd_ready, h, c, ext_drv, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst,
        output cmd_ready, h, c, ext_drv, busy, done, err
    );
endinterface : reg_bus_sequencer_if
`default_nettype wire

// File: rtl/reg_bus_sequencer_idx_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : idx_onehot_dec
// Description : Index to one-hot decoder with enable. Indices >= NREG decode
//               to all-zero (no wrap-around).
// Ports       : en      in  1     decode enable
//               idx     in  IDXW  register index
//               onehot  out NREG  one-hot-or-zero result
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module idx_onehot_dec #(
    parameter int NREG = 4,
    parameter int IDXW = 2
) (
    input  wire logic            en,
    input  wire logic [IDXW-1:0] idx,
    output logic      [NREG-1:0] onehot
);
    // Compare in full integer width so that no out-of-range index can alias
    // onto a valid bit.
    for (genvar i = 0; i < NREG; i++) begin : g_bit
        assign onehot[i] = en && (int'(idx) == i);
    end
endmodule : idx_onehot_dec
`default_nettype wire

// File: rtl/reg_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_sequencer
// Description : Sequences MOVE / SWAP / LOAD register transfers over a shared
//               register bus, generating per-register drive (h) and capture
//               (c) strobes. One command at a time via valid/ready. All
//               outputs are registered.
// Ports       : clk    in  1  clock, rising edge
//               rst    in  1  asynchronous, active-low reset
//               bus    slave modport of reg_bus_sequencer_if
// Config      : ILLEGAL_CHK_EN - when defined, illegal commands are consumed
//               in IDLE without executing and err pulses for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_sequencer
    import reg_bus_pkg::*;
#(
    parameter int NREG = 4,
    parameter int IDXW = 2
) (
    input wire logic          clk,
    input wire logic          rst,
    reg_bus_sequencer_if.slave bus
);

    localparam logic [IDXW-1:0] c_tmp_idx = IDXW'(tmp_idx(NREG));

    state_t          r_state;
    op_t             r_op;
    logic [IDXW-1:0] r_src;
    logic [IDXW-1:0] r_dst;
    logic [NREG-1:0] r_h;
    logic [NREG-1:0] r_c;
    logic            r_ext;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_ready;

    state_t          w_nstate;
    op_t             w_op;
    logic            w_reject;
    logic            w_accept;
    logic            w_h_en;
    logic            w_c_en;
    logic            w_ext;
    logic            w_err;
    logic [IDXW-1:0] w_h_idx;
    logic [IDXW-1:0] w_c_idx;
    logic [NREG-1:0] w_h_dec;
    logic [NREG-1:0] w_c_dec;

    assign w_op = op_t'(bus.cmd_op);

`ifdef ILLEGAL_CHK_EN
    // TMP and above are not user-addressable; src is only meaningful for
    // MOVE/SWAP, so it is not checked on LOAD.
    always_comb begin
        w_reject = 1'b0;
        if (w_op == OP_NOP)
            w_reject = 1'b1;
        if (int'(bus.cmd_dst) >= NREG - 1)
            w_reject = 1'b1;
        if ((w_op == OP_MOVE || w_op == OP_SWAP) &&
            ((int'(bus.cmd_src) >= NREG - 1) || (bus.cmd_src == bus.cmd_dst)))
            w_reject = 1'b1;
    end
`else
    assign w_reject = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid && !w_reject;

    // Next state and the strobe pattern of that next state. Strobes are
    // decoded one cycle early so that they can leave the block registered.
    always_comb begin
        w_nstate = r_state;
        w_h_en   = 1'b0;
        w_c_en   = 1'b0;
        w_ext    = 1'b0;
        w_err    = 1'b0;
        w_h_idx  = r_src;
        w_c_idx  = r_dst;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (w_reject) begin
                        w_err = 1'b1;
                    end else begin
                        case (w_op)
                            OP_MOVE: begin
                                w_nstate = ST_T1;
                                w_h_en   = 1'b1;
                                w_h_idx  = bus.cmd_src;
                                w_c_en   = 1'b1;
                                w_c_idx  = bus.cmd_dst;
                            end
                            OP_SWAP: begin
                                w_nstate = ST_T1;
                                w_h_en   = 1'b1;
                                w_h_idx  = bus.cmd_src;
                                w_c_en   = 1'b1;
                                w_c_idx  = c_tmp_idx;
                            end
                            OP_LOAD: begin
                                w_nstate = ST_T1;
                                w_ext    = 1'b1;
                                w_c_en   = 1'b1;
                                w_c_idx  = bus.cmd_dst;
                            end
                            default: w_nstate = ST_DONE;
                        endcase
                    end
                end
            end
            ST_T1: begin
                if (r_op == OP_SWAP) begin
                    w_nstate = ST_T2;
                    w_h_en   = 1'b1;
                    w_h_idx  = r_dst;
                    w_c_en   = 1'b1;
                    w_c_idx  = r_src;
                end else begin
                    w_nstate = ST_DONE;
                end
            end
            ST_T2: begin
                w_nstate = ST_T3;
                w_h_en   = 1'b1;
                w_h_idx  = c_tmp_idx;
                w_c_en   = 1'b1;
                w_c_idx  = r_dst;
            end
            ST_T3:   w_nstate = ST_DONE;
            ST_DONE: w_nstate = ST_IDLE;
            default: w_nstate = ST_IDLE;
        endcase
    end

    idx_onehot_dec #(.NREG(NREG), .IDXW(IDXW)) u_dec_h (
        .en     (w_h_en),
        .idx    (w_h_idx),
        .onehot (w_h_dec)
    );

    idx_onehot_dec #(.NREG(NREG), .IDXW(IDXW)) u_dec_c (
        .en     (w_c_en),
        .idx    (w_c_idx),
        .onehot (w_c_dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_MOVE;
            r_src   <= '0;
            r_dst   <= '0;
            r_h     <= '0;
            r_c     <= '0;
            r_ext   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_nstate;
            if (w_accept) begin
                r_op  <= w_op;
                r_src <= bus.cmd_src;
                r_dst <= bus.cmd_dst;
            end
            r_h     <= w_h_dec;
            r_c     <= w_c_dec;
            r_ext   <= w_ext;
            r_busy  <= (w_nstate != ST_IDLE);
            r_done  <= (w_nstate == ST_DONE);
            r_ready <= (w_nstate == ST_IDLE);
            r_err   <= w_err;
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.h         = r_h;
    assign bus.c         = r_c;
    assign bus.ext_drv   = r_ext;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule : reg_bus_sequencer
`default_nettype wire
